// File: rtl/layer_serializer.sv
// layer_serializer: captures a parallel layer output vector on o_valid[0]
// and emits it one word per cycle to the next layer.
module layer_serializer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NN-1:0]           o_valid,
  input  logic [NN*dataWidth-1:0] x_in,
  output logic                    x_valid,
  output logic [dataWidth-1:0]    x_out,
  output logic                    busy,
  output logic                    last,
  output logic                    overrun
);
  localparam int IW = NN > 1 ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [dataWidth-1:0] r_buf [NN];
  logic                 w_strobe;
  logic                 w_load;
  logic [IW-1:0]        w_nxt;
  // Only bit 0 matters; the whole vector is masked so every bit is consumed.
  assign w_strobe = |(o_valid & NN'(1));
  assign w_nxt    = r_idx + 1'b1;
  // A strobe is taken when idle or exactly on the final word (back-to-back).
  assign w_load   = w_strobe && (r_state == IDLE || r_idx == LAST_IDX);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_idx   <= '0;
      for (int i = 0; i < NN; i++) r_buf[i] <= '0;
      x_valid <= 1'b0;
      x_out   <= '0;
      busy    <= 1'b0;
      last    <= 1'b0;
      overrun <= 1'b0;
    end else if (w_load) begin
      r_state <= SHIFT;
      r_idx   <= '0;
      for (int i = 0; i < NN; i++) r_buf[i] <= x_in[i*dataWidth +: dataWidth];
      x_valid <= 1'b1;
      x_out   <= x_in[dataWidth-1:0];
      busy    <= 1'b1;
      last    <= (LAST_IDX == '0);
    end else if (r_state == SHIFT && r_idx != LAST_IDX) begin
      r_idx   <= w_nxt;
      x_out   <= r_buf[w_nxt];
      last    <= (w_nxt == LAST_IDX);
      overrun <= overrun | w_strobe;
    end else begin
      r_state <= IDLE;
      r_idx   <= '0;
      x_valid <= 1'b0;
      x_out   <= '0;
      busy    <= 1'b0;
      last    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: directed checks of layer_serializer with NN=10 and NN=1 instances.
module tb_layer_serializer;
  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [9:0]   o_valid = '0;
  logic [159:0] x_in = '0;
  logic         x_valid, busy, last, overrun;
  logic [15:0]  x_out;
  logic [0:0]   o_valid1 = '0;
  logic [15:0]  x_in1 = '0;
  logic         x_valid1, busy1, last1, overrun1;
  logic [15:0]  x_out1;
  logic [19:0]  obs, obs1;
  int checks = 0;
  int errors = 0;

  assign obs  = {x_valid, busy, last, overrun, x_out};
  assign obs1 = {x_valid1, busy1, last1, overrun1, x_out1};

  always #5 CLK = ~CLK;

  layer_serializer #(.NN(10), .dataWidth(16)) dut (
    .CLK(CLK), .RESET(RESET), .o_valid(o_valid), .x_in(x_in),
    .x_valid(x_valid), .x_out(x_out), .busy(busy), .last(last), .overrun(overrun)
  );

  layer_serializer #(.NN(1), .dataWidth(16)) dut1 (
    .CLK(CLK), .RESET(RESET), .o_valid(o_valid1), .x_in(x_in1),
    .x_valid(x_valid1), .x_out(x_out1), .busy(busy1), .last(last1), .overrun(overrun1)
  );

  task automatic load_vec(input logic [15:0] base);
    for (int i = 0; i < 10; i++) x_in[i*16 +: 16] = base + 16'(i);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (obs !== 20'h0 || obs1 !== 20'h0) begin
      errors++;
      $display("FAIL reset: got %h/%h expected 00000/00000", obs, obs1);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_single;
    logic [19:0] exp_v;
    @(negedge CLK);
    o_valid = '1;
    load_vec(16'h0001);
    @(posedge CLK);
    #1 o_valid = '0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge CLK);
      exp_v = (k <= 10) ? {1'b1, 1'b1, k == 10, 1'b0, 16'(k)} : 20'h0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single t+%0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp_v;
    @(negedge CLK);
    o_valid = '1;
    load_vec(16'h0001);
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLK);
      if (k <= 10) exp_v = {2'b11, k == 10, 1'b0, 16'(k)};
      else if (k <= 20) exp_v = {2'b11, k == 20, 1'b0, 16'h0100 + 16'(k - 11)};
      else exp_v = 20'h0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b t+%0d: got %h expected %h", k, obs, exp_v);
      end
      o_valid = (k == 10) ? '1 : '0;
      if (k == 10) load_vec(16'h0100);
    end
  endtask

  task automatic test_overrun;
    logic [19:0] exp_v;
    @(negedge CLK);
    o_valid = '1;
    load_vec(16'h0001);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k <= 10) exp_v = {2'b11, k == 10, k >= 5, 16'(k)};
      else exp_v = {3'b000, 1'b1, 16'h0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL overrun t+%0d: got %h expected %h", k, obs, exp_v);
      end
      o_valid = (k == 4) ? '1 : '0;
      x_in = (k == 4) ? {10{16'hFFFF}} : x_in;
    end
  endtask

  task automatic test_reset_mid;
    logic [19:0] exp_v;
    @(negedge CLK);
    o_valid = '1;
    load_vec(16'h0010);
    @(posedge CLK);
    #1 o_valid = '0;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid async: got %h expected 00000", obs);
    end
    o_valid = '1;
    load_vec(16'h0030);
    @(negedge CLK);
    RESET = 1'b0;
    o_valid = '0;
    @(negedge CLK);
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid strobe during reset: got %h expected 00000", obs);
    end
    o_valid = '1;
    load_vec(16'h0020);
    @(posedge CLK);
    #1 o_valid = '0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge CLK);
      exp_v = (k <= 10) ? {2'b11, k == 10, 1'b0, 16'h0020 + 16'(k - 1)} : 20'h0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid fresh t+%0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_nn1;
    @(negedge CLK);
    o_valid1 = 1'b1;
    x_in1 = 16'hBEEF;
    @(posedge CLK);
    #1 o_valid1 = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs1 !== {4'b1110, 16'hBEEF}) begin
      errors++;
      $display("FAIL nn1 word: got %h expected %h", obs1, {4'b1110, 16'hBEEF});
    end
    @(negedge CLK);
    checks++;
    if (obs1 !== 20'h0) begin
      errors++;
      $display("FAIL nn1 idle: got %h expected 00000", obs1);
    end
    o_valid1 = 1'b1;
    x_in1 = 16'h1234;
    @(negedge CLK);
    x_in1 = 16'h5678;
    @(negedge CLK);
    o_valid1 = 1'b0;
    checks++;
    if (obs1 !== {4'b1110, 16'h5678}) begin
      errors++;
      $display("FAIL nn1 b2b: got %h expected %h", obs1, {4'b1110, 16'h5678});
    end
    @(negedge CLK);
    checks++;
    if (obs1 !== 20'h0) begin
      errors++;
      $display("FAIL nn1 b2b idle: got %h expected 00000", obs1);
    end
  endtask

  task automatic test_idle;
    x_in = {10{16'hA5A5}};
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      o_valid = k[0] ? 10'h3FE : 10'h2AA;
      checks++;
      if (obs !== 20'h0) begin
        errors++;
        $display("FAIL idle %0d: got %h expected 00000", k, obs);
      end
    end
    o_valid = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_idle;
    test_overrun;
    test_reset_mid;
    test_nn1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter NN, default 10: number of neuron outputs in the captured vector.
REQ-002 SHALL have parameter dataWidth, default 16: width of each neuron output word.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port o_valid  input  NN  per-neuron output-valid strobes from the producing layer.
REQ-006 SHALL have port x_in  input  NN*dataWidth  parallel layer outputs; element i = x_in[i*dataWidth +: dataWidth].
REQ-007 SHALL have port x_valid  output  1  serial word valid, feeding the next layer's input-valid.
REQ-008 SHALL have port x_out  output  dataWidth  serial word, feeding the next layer's data input.
REQ-009 SHALL have port busy  output  1  high while a captured vector is being emitted.
REQ-010 SHALL have port last  output  1  high together with the final word of a vector.
REQ-011 SHALL have port overrun  output  1  sticky flag: a vector was dropped.

Function
REQ-012 SHALL have two states: IDLE and SHIFT.
REQ-013 SHALL define the capture strobe as o_valid[0]; other o_valid bits SHALL be ignored (all neurons of a layer fire together).
REQ-014 SHALL, in IDLE with the capture strobe high at edge t, copy x_in into an internal NN-word buffer, clear the index counter to 0, and enter SHIFT.
REQ-015 SHALL, in SHIFT, drive x_valid=1 and x_out=buffer[index] for exactly NN consecutive cycles, in index order 0..NN-1, with no gaps.
REQ-016 SHALL register x_out, x_valid, busy and last: first word valid in cycle t+1, last word in cycle t+NN.
REQ-017 SHALL assert last only in the cycle where index==NN-1 and x_valid=1.
REQ-018 SHALL assert busy exactly while in SHIFT.
REQ-019 SHALL, after emitting word NN-1 with no new strobe, return to IDLE with x_valid=0, busy=0, last=0 next cycle.
REQ-020 SHALL drive x_out to 0 whenever x_valid=0.
REQ-021 SHALL accept a strobe that arrives at the same edge as the last word (index==NN-1): recapture x_in, reset index to 0, stay in SHIFT, and emit the new word 0 in the very next cycle (back-to-back, no idle cycle).
REQ-022 SHALL ignore a strobe during SHIFT with index<NN-1: buffer and emission unaffected, overrun set to 1.
REQ-023 SHALL keep overrun at 1 until RESET; no other clear.
REQ-024 SHALL size the index counter as ceil(log2(NN)) bits, minimum 1; it SHALL never exceed NN-1.
REQ-025 SHALL pass words unmodified (no sign extension, rounding or reordering within a word).
REQ-026 SHALL support NN=1: one word per strobe, last asserted with it.

Reset
REQ-027 SHALL, on RESET high, immediately and asynchronously force state=IDLE, index=0, buffer=0, x_valid=0, x_out=0, busy=0, last=0, overrun=0.
REQ-028 SHALL, on RESET mid-SHIFT, abandon the vector with no further words emitted; first strobe after release SHALL be captured normally.
REQ-029 SHALL ignore a strobe coincident with RESET high.

Verification
REQ-030 SHALL verify single vector: NN=10, x_in words 0x0001..0x000A, o_valid=all-ones for 1 cycle at t -> x_valid high t+1..t+10, x_out 0x0001..0x000A in order, last only at t+10, busy low at t+11.
REQ-031 SHALL verify back-to-back: second strobe with words 0x0100..0x0109 at t+10 -> x_valid continuous t+1..t+20, 0x0109 at t+20, last at t+10 and t+20, overrun=0.
REQ-032 SHALL verify overrun: second strobe at t+4 -> emission of first vector unchanged through t+10, overrun=1 from t+5 and stays 1 after return to IDLE.
REQ-033 SHALL verify reset mid-SHIFT: RESET asserted asynchronously between edges t+3 and t+4 -> x_valid, busy, overrun drop to 0 without waiting for an edge; later strobe emits fresh vector from word 0.
REQ-034 SHALL verify NN=1 build: strobe with 0xBEEF -> one cycle x_valid=1, x_out=0xBEEF, last=1, then IDLE.
REQ-035 SHALL verify idle hygiene: o_valid[NN-1:1] toggling with o_valid[0]=0 -> x_valid stays 0, x_out stays 0.
